// File: rtl/mcu_ahb_master_if.sv
// Command/response handshake and AHB-lite bus bundle for mcu_ahb_master.
// The master modport is the block's view; slave is the view of whatever drives the other side.
interface mcu_ahb_master_if #(
  parameter int HADDR_W = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [HADDR_W-1:0] cmd_addr;
  logic [2:0]         cmd_size;
  logic [31:0]        cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [1:0]         HTRANS;
  logic [HADDR_W-1:0] HADDR;
  logic [2:0]         HSIZE;
  logic               HWRITE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HRESP;
  logic [31:0]        HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HTRANS, HADDR, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HTRANS, HADDR, HSIZE, HWRITE, HWDATA
  );
endinterface

// File: rtl/mcu_ahb_master.sv
// Single-transfer AHB-lite master: one NONSEQ at a time, response held until accepted.
// Optional macro MCU_AHB_MASTER_ALIGNCHK_EN rejects oversized or misaligned commands without a bus transfer.
module mcu_ahb_master #(
  parameter int HADDR_W = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  mcu_ahb_master_if.master      bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR  = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e             state_q, state_d;
  logic [HADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]         hsize_q, hsize_d;
  logic               hwrite_q, hwrite_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        hwdata_q, hwdata_d;
  logic [1:0]         htrans_q, htrans_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               accept_s;
  logic               misalign_s;

`ifdef MCU_AHB_MASTER_ALIGNCHK_EN
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lsb);
    case (size)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = addr_lsb[0];
      3'b010:  misaligned = (addr_lsb != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  assign misalign_s = misaligned(bus.cmd_size, bus.cmd_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign accept_s = bus.cmd_valid & cmd_ready_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      haddr_q     <= {HADDR_W{1'b0}};
      hsize_q     <= 3'b000;
      hwrite_q    <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      hwdata_q    <= 32'h0000_0000;
      htrans_q    <= HTRANS_IDLE;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // An error reported with HREADY already high in DATA completes immediately as an error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = misalign_s ? S_RSP : S_ADDR;
        else          state_d = S_IDLE;
      end
      S_ADDR: begin
        if (bus.HREADY) state_d = S_DATA;
        else            state_d = S_ADDR;
      end
      S_DATA: begin
        if (bus.HRESP)       state_d = bus.HREADY ? S_RSP : S_ERR;
        else if (bus.HREADY) state_d = S_RSP;
        else                 state_d = S_DATA;
      end
      S_ERR: begin
        if (bus.HREADY && bus.HRESP) state_d = S_RSP;
        else                         state_d = S_ERR;
      end
      S_RSP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
        else               state_d = S_RSP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus address fields only change when a transfer is actually launched, so they hold otherwise.
  always_comb begin
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && misalign_s) begin
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
        end else if (accept_s) begin
          haddr_d  = bus.cmd_addr;
          hsize_d  = bus.cmd_size;
          hwrite_d = bus.cmd_write;
          wdata_d  = bus.cmd_wdata;
        end else begin
          err_d = err_q;
        end
      end
      S_DATA: begin
        if (bus.HREADY) begin
          err_d   = bus.HRESP;
          rdata_d = (bus.HRESP || hwrite_q) ? 32'h0000_0000 : bus.HRDATA;
        end else begin
          err_d = err_q;
        end
      end
      S_ERR: begin
        if (bus.HREADY && bus.HRESP) begin
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        err_d = err_q;
      end
    endcase
    htrans_d    = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwdata_d    = ((state_d == S_DATA) && hwrite_d) ? wdata_d : 32'h0000_0000;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = hwdata_q;
endmodule
